mem_access_ctrl: RTL

Load/store sequencer between the SPARC datapath and the byte-addressable data RAM. It decodes op3 into size, sign, direction and doubleword fields, and checks address alignment. It drives the RAM through the MOC/MFC handshake, performing two word beats for LDD/STD. It sign- or zero-extends load data and reports completion, misalignment or bus timeout to the control unit.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/mem_type_decode.sv | 35 +++
 rtl/mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store sequencer: op3 values, access sizes
// and controller states.
package mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_STD  = 6'b000111;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FAULT = 3'd1,
    ACC0  = 3'd2,
    GAP   = 3'd3,
    ACC1  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Doublewords need 8-byte alignment; otherwise the size sets the rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic dbl,
                                         input logic [2:0] lo);
    logic m;
    if (dbl) begin
      m = (lo != 3'b000);
    end else begin
      case (size)
        SZ_HALF: m = lo[0];
        SZ_WORD: m = (lo[1:0] != 2'b00);
        default: m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-RAM bus: MOC/MFC handshake plus address, size, direction and data.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              mem_moc;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_mfc;

  modport master (
    output mem_moc, mem_rw, mem_size, mem_addr, mem_wdata,
    input  mem_rdata, mem_mfc
  );

  modport slave (
    input  mem_moc, mem_rw, mem_size, mem_addr, mem_wdata,
    output mem_rdata, mem_mfc
  );
endinterface

// File: rtl/mem_type_decode.sv
// Combinational op3 decode into access size, sign, direction and doubleword.
module mem_type_decode
  import mem_pkg::*;
(
  input  logic [5:0] op3,
  output logic [1:0] size,
  output logic       sign,
  output logic       is_store,
  output logic       is_double,
  output logic       legal
);

  // op3 classification; anything not listed is an illegal memory op
  always_comb begin
    size      = SZ_WORD;
    sign      = 1'b0;
    is_store  = 1'b0;
    is_double = 1'b0;
    legal     = 1'b1;
    case (op3)
      OP_LDSB: begin size = SZ_BYTE; sign = 1'b1; end
      OP_LDSH: begin size = SZ_HALF; sign = 1'b1; end
      OP_LDUB: size = SZ_BYTE;
      OP_LDUH: size = SZ_HALF;
      OP_LD:   size = SZ_WORD;
      OP_LDD:  is_double = 1'b1;
      OP_STB:  begin size = SZ_BYTE; is_store = 1'b1; end
      OP_STH:  begin size = SZ_HALF; is_store = 1'b1; end
      OP_ST:   is_store = 1'b1;
      OP_STD:  begin is_store = 1'b1; is_double = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: decodes op3, checks alignment, runs one or two
// MOC/MFC beats on the data RAM and reports completion or faults.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        op3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              misalign,
  output logic              bad_op,
  output logic              bus_err,
  mem_access_ctrl_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_r, state_n_s;
  logic [5:0]        op3_r, op_s;
  logic [ADDR_W-1:0] addr_r, addr_s, maddr_r, maddr_n_s;
  logic [DATA_W-1:0] wd0_r, wd1_r, wd0_s, wd1_s;
  logic [DATA_W-1:0] rdin_r, rd0_tmp_r, mwdata_r, mwdata_n_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [1:0]        dec_size_s, size_r, size_n_s;
  logic              dec_sign_s, dec_store_s, dec_dbl_s, dec_legal_s;
  logic              idle_s, mis_s, tmo_s, mfc_r;
  logic              moc_r, moc_n_s, rw_r, rw_n_s;
  logic              done_n_s, mis_n_s, bad_n_s, berr_n_s;

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] sz, input logic sgn);
    case (sz)
      SZ_BYTE: return {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      SZ_HALF: return {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mask_store(input logic [DATA_W-1:0] d,
                                                   input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return {{(DATA_W-8){1'b0}}, d[7:0]};
      SZ_HALF: return {{(DATA_W-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  // In IDLE the live request is decoded so the fault/access choice is made the same cycle.
  assign idle_s = (state_r == IDLE);
  assign op_s   = idle_s ? op3    : op3_r;
  assign addr_s = idle_s ? addr   : addr_r;
  assign wd0_s  = idle_s ? wdata0 : wd0_r;
  assign wd1_s  = idle_s ? wdata1 : wd1_r;
  assign mis_s  = is_misaligned(dec_size_s, dec_dbl_s, addr_s[2:0]);
  assign tmo_s  = (cnt_r == CNT_W'(TIMEOUT));

  mem_type_decode u_dec (
    .op3       (op_s),
    .size      (dec_size_s),
    .sign      (dec_sign_s),
    .is_store  (dec_store_s),
    .is_double (dec_dbl_s),
    .legal     (dec_legal_s)
  );

  // Next-state and completion flags
  always_comb begin
    state_n_s = state_r;
    done_n_s  = 1'b0;
    mis_n_s   = 1'b0;
    bad_n_s   = 1'b0;
    berr_n_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!start) begin
          state_n_s = IDLE;
        end else if (!dec_legal_s) begin
          state_n_s = FAULT; done_n_s = 1'b1; bad_n_s = 1'b1;
        end else if (mis_s) begin
          state_n_s = FAULT; done_n_s = 1'b1; mis_n_s = 1'b1;
        end else begin
          state_n_s = ACC0;
        end
      end
      FAULT: state_n_s = IDLE;
      ACC0: begin
        if (mfc_r) begin
          state_n_s = dec_dbl_s ? GAP : DONE;
          done_n_s  = !dec_dbl_s;
        end else if (tmo_s) begin
          state_n_s = FAULT; done_n_s = 1'b1; berr_n_s = 1'b1;
        end else begin
          state_n_s = ACC0;
        end
      end
      GAP: state_n_s = ACC1;
      ACC1: begin
        if (mfc_r) begin
          state_n_s = DONE; done_n_s = 1'b1;
        end else if (tmo_s) begin
          state_n_s = FAULT; done_n_s = 1'b1; berr_n_s = 1'b1;
        end else begin
          state_n_s = ACC1;
        end
      end
      DONE:    state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // Bus values for the state being entered, so the registered bus lines up with the state
  always_comb begin
    moc_n_s    = 1'b0;
    rw_n_s     = 1'b0;
    size_n_s   = SZ_BYTE;
    maddr_n_s  = {ADDR_W{1'b0}};
    mwdata_n_s = {DATA_W{1'b0}};
    case (state_n_s)
      ACC0: begin
        moc_n_s    = 1'b1;
        rw_n_s     = !dec_store_s;
        size_n_s   = dec_size_s;
        maddr_n_s  = addr_s;
        mwdata_n_s = dec_store_s ? mask_store(wd0_s, dec_size_s) : {DATA_W{1'b0}};
      end
      ACC1: begin
        moc_n_s    = 1'b1;
        rw_n_s     = !dec_store_s;
        size_n_s   = SZ_WORD;
        maddr_n_s  = addr_s + ADDR_W'(4);
        mwdata_n_s = dec_store_s ? wd1_s : {DATA_W{1'b0}};
      end
      default: begin
        moc_n_s    = 1'b0;
        rw_n_s     = 1'b0;
        size_n_s   = SZ_BYTE;
        maddr_n_s  = {ADDR_W{1'b0}};
        mwdata_n_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // State register and request latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      op3_r   <= 6'b000000;
      addr_r  <= {ADDR_W{1'b0}};
      wd0_r   <= {DATA_W{1'b0}};
      wd1_r   <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_n_s;
      if (idle_s && start) begin
        op3_r  <= op3;
        addr_r <= addr;
        wd0_r  <= wdata0;
        wd1_r  <= wdata1;
      end
    end
  end

  // Beat cycle counter, restarts at 1 on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_n_s != state_r) begin
      cnt_r <= CNT_W'(1);
    end else if (!tmo_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // MFC is only honoured while MOC is actually high, and is registered with its data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mfc_r  <= 1'b0;
      rdin_r <= {DATA_W{1'b0}};
    end else begin
      mfc_r  <= mem.mem_mfc & moc_r;
      rdin_r <= mem.mem_rdata;
    end
  end

  // Registered status and bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      misalign <= 1'b0;
      bad_op   <= 1'b0;
      bus_err  <= 1'b0;
      moc_r    <= 1'b0;
      rw_r     <= 1'b0;
      size_r   <= SZ_BYTE;
      maddr_r  <= {ADDR_W{1'b0}};
      mwdata_r <= {DATA_W{1'b0}};
    end else begin
      busy     <= (state_n_s != IDLE);
      done     <= done_n_s;
      misalign <= mis_n_s;
      bad_op   <= bad_n_s;
      bus_err  <= berr_n_s;
      moc_r    <= moc_n_s;
      rw_r     <= rw_n_s;
      size_r   <= size_n_s;
      maddr_r  <= maddr_n_s;
      mwdata_r <= mwdata_n_s;
    end
  end

  // Load results commit only on a completed load; a double parks beat 0 until beat 1 lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0    <= {DATA_W{1'b0}};
      rdata1    <= {DATA_W{1'b0}};
      rd0_tmp_r <= {DATA_W{1'b0}};
    end else if (state_r == ACC0 && mfc_r && !dec_store_s) begin
      if (dec_dbl_s) begin
        rd0_tmp_r <= rdin_r;
      end else begin
        rdata0 <= extend_load(rdin_r, dec_size_s, dec_sign_s);
        rdata1 <= {DATA_W{1'b0}};
      end
    end else if (state_r == ACC1 && mfc_r && !dec_store_s) begin
      rdata0 <= rd0_tmp_r;
      rdata1 <= rdin_r;
    end
  end

  assign mem.mem_moc   = moc_r;
  assign mem.mem_rw    = rw_r;
  assign mem.mem_size  = size_r;
  assign mem.mem_addr  = maddr_r;
  assign mem.mem_wdata = mwdata_r;

endmodule
